// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue/writeback stage: opcodes, instruction layout, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package alu_issue_pkg;

   localparam int OP_W     = 3;
   localparam int REG_AW   = 3;
   localparam int NUM_REGS = 8;
   localparam int IMM_BITS = 11;
   localparam int INSTR_W  = 24;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_ADD  = 3'b010,
      OP_ILL  = 3'b011,
      OP_ANDN = 3'b100,
      OP_ORN  = 3'b101,
      OP_SUB  = 3'b110,
      OP_HALT = 3'b111
   } op_e;

   typedef struct packed {
      op_e                 op;
      logic [REG_AW-1:0]   rd;
      logic [REG_AW-1:0]   ra;
      logic [REG_AW-1:0]   rb;
      logic                use_imm;
      logic [IMM_BITS-1:0] imm;
   } instr_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   // Ops that actually reach the ALU; ILL and HALT are consumed by the stage.
   function automatic logic op_is_legal(input op_e op);
      return (op != OP_ILL) && (op != OP_HALT);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file, r0 hardwired to zero; 2 operand read ports, 1 debug read port, 1 write port.
// Latency: reads are combinational, a write is visible after the writing edge.
// Backpressure: none; a write is taken whenever wr_en is high.
// Ports: clk/reset_n; ra_addr/ra_data, rb_addr/rb_data operand reads; dbg_addr/dbg_data debug read;
//        wr_en/wr_addr/wr_data synchronous write (writes to r0 are dropped).
module alu_regfile
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];
   logic [DATA_W-1:0] mem_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_en && (wr_addr != '0)) begin
         mem_d[wr_addr] = wr_data;
      end
      mem_d[0] = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign ra_data  = (ra_addr  == '0) ? '0 : mem_q[ra_addr];
   assign rb_data  = (rb_addr  == '0) ? '0 : mem_q[rb_addr];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational ALU: decode, operand read with forwarding, writeback, flags, HALT FSM.
// Latency: accepted at edge N -> ALU inputs registered at N, result written/flags/retired updated at N+1; 1 op/cycle.
// Backpressure: in_ready is high only in RUN; the ALU never stalls, so RUN always accepts.
// Ports: in_valid/in_ready/in_instr instruction handshake; resume leaves HALTED; alu_a/b/f/valid drive the ALU,
//        alu_y/cout/zero come back combinationally; flag_zero/flag_cout/halted/err/retired status; dbg_raddr/dbg_rdata debug read.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 11,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [23:0]       in_instr,
   input  logic              resume,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_f,
   output logic              alu_valid,
   input  logic [DATA_W-1:0] alu_y,
   input  logic              alu_cout,
   input  logic              alu_zero,
   output logic              flag_zero,
   output logic              flag_cout,
   output logic              halted,
   output logic              err,
   output logic [CNT_W-1:0]  retired,
   input  logic [2:0]        dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   instr_t            instr;
   logic              accept;
   logic              issue;
   logic              fwd_a;
   logic              fwd_b;
   logic [DATA_W-1:0] rf_a;
   logic [DATA_W-1:0] rf_b;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] opnd_a;
   logic [DATA_W-1:0] opnd_b;

   state_e            state_q,     state_d;
   logic              in_ready_q,  in_ready_d;
   logic              halted_q,    halted_d;
   logic [DATA_W-1:0] alu_a_q,     alu_a_d;
   logic [DATA_W-1:0] alu_b_q,     alu_b_d;
   logic [2:0]        alu_f_q,     alu_f_d;
   logic [2:0]        rd_q,        rd_d;
   logic              alu_valid_q, alu_valid_d;
   logic              flag_zero_q, flag_zero_d;
   logic              flag_cout_q, flag_cout_d;
   logic              err_q,       err_d;
   logic [CNT_W-1:0]  retired_q,   retired_d;

   assign instr    = instr_t'(in_instr);
   assign accept   = in_valid && in_ready_q;
   assign issue    = accept && op_is_legal(instr.op);
   assign imm_sext = {{(DATA_W-IMM_W){instr.imm[IMM_W-1]}}, instr.imm};

   // The op sitting in the issue register has not written back yet; a reader
   // of its destination must take the live ALU result so dependent ops need no bubble.
   assign fwd_a  = alu_valid_q && (rd_q != '0) && (rd_q == instr.ra);
   assign fwd_b  = alu_valid_q && (rd_q != '0) && !instr.use_imm && (rd_q == instr.rb);
   assign opnd_a = fwd_a ? alu_y : rf_a;
   assign opnd_b = instr.use_imm ? imm_sext : (fwd_b ? alu_y : rf_b);

   alu_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk      (clk),
      .reset_n  (reset_n),
      .ra_addr  (instr.ra),
      .ra_data  (rf_a),
      .rb_addr  (instr.rb),
      .rb_data  (rf_b),
      .dbg_addr (dbg_raddr),
      .dbg_data (dbg_rdata),
      .wr_en    (alu_valid_q),
      .wr_addr  (rd_q),
      .wr_data  (alu_y)
   );

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_f_d     = alu_f_q;
      rd_d        = rd_q;
      flag_zero_d = flag_zero_q;
      flag_cout_d = flag_cout_q;
      retired_d   = retired_q;

      if (state_q == ST_RUN) begin
         if (accept && (instr.op == OP_HALT)) begin
            state_d = ST_HALTED;
         end
      end else begin
         if (resume) begin
            state_d = ST_RUN;
         end
      end

      alu_valid_d = issue;
      if (issue) begin
         alu_a_d = opnd_a;
         alu_b_d = opnd_b;
         alu_f_d = instr.op;
         rd_d    = instr.rd;
      end

      // Writeback of the op in the issue register happens on every edge it is live.
      if (alu_valid_q) begin
         flag_zero_d = alu_zero;
         flag_cout_d = alu_cout;
         retired_d   = retired_q + CNT_W'(1);
      end

      err_d      = err_q | (accept && (instr.op == OP_ILL));
      in_ready_d = (state_d == ST_RUN);
      halted_d   = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         in_ready_q  <= 1'b1;
         halted_q    <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_f_q     <= '0;
         rd_q        <= '0;
         alu_valid_q <= 1'b0;
         flag_zero_q <= 1'b0;
         flag_cout_q <= 1'b0;
         err_q       <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         halted_q    <= halted_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_f_q     <= alu_f_d;
         rd_q        <= rd_d;
         alu_valid_q <= alu_valid_d;
         flag_zero_q <= flag_zero_d;
         flag_cout_q <= flag_cout_d;
         err_q       <= err_d;
         retired_q   <= retired_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign halted    = halted_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_f     = alu_f_q;
   assign alu_valid = alu_valid_q;
   assign flag_zero = flag_zero_q;
   assign flag_cout = flag_cout_q;
   assign err       = err_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand-written HALT/illegal/wrap/reset sequences,
// and a random phase checked against a sequential-semantics reference model with a one-op commit delay.
module tb_alu_issue_stage;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b1;
   logic        in_valid  = 1'b0;
   logic        resume    = 1'b0;
   logic [23:0] in_instr  = '0;
   logic [2:0]  dbg_raddr = '0;
   logic        in_ready;
   logic [31:0] alu_a, alu_b, alu_y, dbg_rdata;
   logic [2:0]  alu_f;
   logic        alu_valid, alu_cout, alu_zero;
   logic        flag_zero, flag_cout, halted, err;
   logic [15:0] retired;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(32), .IMM_W(11), .CNT_W(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .resume    (resume),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_valid (alu_valid),
      .alu_y     (alu_y),
      .alu_cout  (alu_cout),
      .alu_zero  (alu_zero),
      .flag_zero (flag_zero),
      .flag_cout (flag_cout),
      .halted    (halted),
      .err       (err),
      .retired   (retired),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata)
   );

   // Behavioural ALU: returns {cout, zero, y}.
   function automatic logic [33:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] y;
      logic        c;
      y = '0;
      c = 1'b0;
      s = '0;
      case (f)
         3'd0: y = a & b;
         3'd1: y = a | b;
         3'd2: begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32]; end
         3'd4: y = a & ~b;
         3'd5: y = a | ~b;
         3'd6: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; y = s[31:0]; c = s[32]; end
         default: y = '0;
      endcase
      return {c, (y == 32'd0), y};
   endfunction

   logic [33:0] alu_out;
   assign alu_out  = alu_fn(alu_f, alu_a, alu_b);
   assign alu_y    = alu_out[31:0];
   assign alu_zero = alu_out[32];
   assign alu_cout = alu_out[33];

   function automatic logic [23:0] mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic ui, input logic [10:0] imm);
      return {op, rd, ra, rb, ui, imm};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic read_reg(input logic [2:0] r, input string name, input logic [31:0] exp);
      dbg_raddr = r;
      #1;
      chk(name, {32'd0, dbg_rdata}, {32'd0, exp});
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      in_valid = 1'b0;
      resume   = 1'b0;
      in_instr = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // arch: register contents under plain sequential execution of accepted ops.
   // comm: what the register file shows; an op's result lands there one edge after it was accepted.
   logic [31:0] arch [8];
   logic [31:0] comm [8];
   bit          m_halt, m_err, pv, p_z, p_c, m_fz, m_fc;
   logic [2:0]  p_rd, e_f;
   logic [31:0] p_y, e_a, e_b;
   int          m_ret;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin arch[i] = '0; comm[i] = '0; end
      m_halt = 0; m_err = 0; pv = 0; p_z = 0; p_c = 0; m_fz = 0; m_fc = 0;
      p_rd = '0; e_f = '0; p_y = '0; e_a = '0; e_b = '0; m_ret = 0;
   endtask

   task automatic model_edge();
      logic [2:0]  op, rd, ra, rb;
      logic [31:0] a, b;
      logic [33:0] r;
      if (pv) begin
         if (p_rd != 3'd0) comm[p_rd] = p_y;
         m_fz = p_z;
         m_fc = p_c;
         m_ret++;
      end
      pv = 0;
      op = in_instr[23:21]; rd = in_instr[20:18]; ra = in_instr[17:15]; rb = in_instr[14:12];
      if (m_halt) begin
         if (resume) m_halt = 0;
      end else if (in_valid) begin
         if (op == 3'd3) m_err = 1;
         else if (op == 3'd7) m_halt = 1;
         else begin
            a = arch[ra];
            b = in_instr[11] ? {{21{in_instr[10]}}, in_instr[10:0]} : arch[rb];
            r = alu_fn(op, a, b);
            if (rd != 3'd0) arch[rd] = r[31:0];
            pv = 1; p_rd = rd; p_y = r[31:0]; p_z = r[32]; p_c = r[33];
            e_a = a; e_b = b; e_f = op;
         end
      end
   endtask

   task automatic model_check();
      logic [2:0] r;
      int         ret16;
      ret16 = m_ret % 65536;
      chk("rnd_alu_valid", alu_valid, pv);
      if (pv) begin
         chk("rnd_alu_a", alu_a, e_a);
         chk("rnd_alu_b", alu_b, e_b);
         chk("rnd_alu_f", alu_f, e_f);
      end
      chk("rnd_retired", retired, ret16);
      chk("rnd_flag_zero", flag_zero, m_fz);
      chk("rnd_flag_cout", flag_cout, m_fc);
      chk("rnd_err", err, m_err);
      chk("rnd_halted", halted, m_halt);
      chk("rnd_in_ready", in_ready, !m_halt);
      r = 3'($urandom_range(0, 7));
      read_reg(r, "rnd_reg", comm[r]);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [23:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] rd_val;   // value read back from rd after writeback
      logic        z;        // flag_zero after writeback
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd5),     32'd0,  32'd5,          3'd2, 32'd5,          1'b0};
      tbl[1] = '{mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd7),     32'd0,  32'd7,          3'd2, 32'd7,          1'b0};
      tbl[2] = '{mk(3'd2, 3'd2, 3'd1, 3'd1, 1'b0, 11'd0),     32'd7,  32'd7,          3'd2, 32'd14,         1'b0};
      tbl[3] = '{mk(3'd6, 3'd3, 3'd1, 3'd1, 1'b0, 11'd0),     32'd7,  32'd7,          3'd6, 32'd0,          1'b1};
      tbl[4] = '{mk(3'd2, 3'd5, 3'd0, 3'd0, 1'b1, 11'h7FF),   32'd0,  32'hFFFF_FFFF,  3'd2, 32'hFFFF_FFFF,  1'b0};
      tbl[5] = '{mk(3'd1, 3'd6, 3'd2, 3'd0, 1'b1, 11'd1),     32'd14, 32'd1,          3'd1, 32'd15,         1'b0};
      tbl[6] = '{mk(3'd4, 3'd7, 3'd6, 3'd2, 1'b0, 11'd0),     32'd15, 32'd14,         3'd4, 32'd1,          1'b0};
      tbl[7] = '{mk(3'd2, 3'd0, 3'd2, 3'd0, 1'b1, 11'd1),     32'd14, 32'd1,          3'd2, 32'd0,          1'b0};

      #1;
      do_reset();

      // Reset state
      chk("rst_alu_valid", alu_valid, 1'b0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_f", alu_f, 3'd0);
      chk("rst_retired", retired, 16'd0);
      chk("rst_flags", {flag_zero, flag_cout, err, halted}, 4'b0000);
      chk("rst_in_ready", in_ready, 1'b1);
      read_reg(3'd1, "rst_r1", 32'd0);

      // Back-to-back table, one instruction per cycle
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_instr = tbl[k].instr;
         cyc();
         chk($sformatf("tbl%0d_valid", k), alu_valid, 1'b1);
         chk($sformatf("tbl%0d_alu_a", k), alu_a, tbl[k].a);
         chk($sformatf("tbl%0d_alu_b", k), alu_b, tbl[k].b);
         chk($sformatf("tbl%0d_alu_f", k), alu_f, tbl[k].f);
         chk($sformatf("tbl%0d_retired", k), retired, k);
         if (k > 0) begin
            read_reg(tbl[k-1].instr[20:18], $sformatf("tbl%0d_wb", k-1), tbl[k-1].rd_val);
            chk($sformatf("tbl%0d_zero", k-1), flag_zero, tbl[k-1].z);
         end
      end
      in_valid = 1'b0;
      cyc();
      chk("tbl_end_valid", alu_valid, 1'b0);
      chk("tbl_end_retired", retired, 16'd8);
      read_reg(3'd0, "tbl_r0_discard", 32'd0);
      read_reg(3'd3, "tbl_r3_sub", 32'd0);

      // Illegal op followed by a legal one
      in_valid = 1'b1;
      in_instr = mk(3'd3, 3'd5, 3'd1, 3'd1, 1'b0, 11'd0);
      cyc();
      chk("ill_not_issued", alu_valid, 1'b0);
      chk("ill_err", err, 1'b1);
      in_instr = mk(3'd2, 3'd4, 3'd0, 3'd0, 1'b1, 11'd1);
      cyc();
      chk("ill_next_issued", alu_valid, 1'b1);
      in_valid = 1'b0;
      cyc();
      chk("ill_retired", retired, 16'd9);
      chk("ill_err_sticky", err, 1'b1);
      read_reg(3'd4, "ill_r4", 32'd1);
      read_reg(3'd5, "ill_r5_untouched", 32'hFFFF_FFFF);

      // ADD then HALT with in_valid held high
      in_valid = 1'b1;
      in_instr = mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd3);
      cyc();
      in_instr = mk(3'd7, 3'd0, 3'd0, 3'd0, 1'b0, 11'd0);
      cyc();
      chk("halt_halted", halted, 1'b1);
      chk("halt_in_ready", in_ready, 1'b0);
      chk("halt_add_retired", retired, 16'd10);
      read_reg(3'd1, "halt_r1", 32'd3);
      in_instr = mk(3'd2, 3'd2, 3'd0, 3'd0, 1'b1, 11'd9);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk($sformatf("halt_hold%0d_ready", i), in_ready, 1'b0);
         chk($sformatf("halt_hold%0d_valid", i), alu_valid, 1'b0);
      end
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      chk("resume_in_ready", in_ready, 1'b1);
      chk("resume_halted", halted, 1'b0);
      chk("resume_not_yet", alu_valid, 1'b0);
      cyc();
      chk("resume_accept", alu_valid, 1'b1);
      chk("resume_alu_b", alu_b, 32'd9);
      in_valid = 1'b0;
      cyc();
      chk("resume_retired", retired, 16'd11);
      read_reg(3'd2, "resume_r2", 32'd9);

      // Randomised phase against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 800; n++) begin
         int sel;
         logic [2:0] op;
         sel = $urandom_range(0, 19);
         if (sel < 16)       op = 3'(sel % 7 == 3 ? 2 : sel % 7);
         else if (sel < 18)  op = 3'd3;
         else if (sel == 18) op = 3'd7;
         else                op = 3'd6;
         in_valid = ($urandom_range(0, 3) != 0);
         resume   = ($urandom_range(0, 2) == 0);
         in_instr = mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)));
         model_edge();
         cyc();
         model_check();
      end
      in_valid = 1'b0;
      resume   = 1'b0;

      // Retire counter wrap
      do_reset();
      in_valid = 1'b1;
      in_instr = mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 11'd1);
      repeat (65535) cyc();
      in_valid = 1'b0;
      cyc();
      chk("wrap_ffff", retired, 16'hFFFF);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("wrap_zero", retired, 16'd0);

      // Reset in the middle of a stream
      in_valid = 1'b1;
      in_instr = mk(3'd2, 3'd3, 3'd0, 3'd0, 1'b1, 11'h55);
      cyc();
      cyc();
      chk("mid_pre_valid", alu_valid, 1'b1);
      read_reg(3'd3, "mid_pre_r3", 32'h55);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", alu_valid, 1'b0);
      chk("mid_rst_retired", retired, 16'd0);
      chk("mid_rst_alu_b", alu_b, 32'd0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      read_reg(3'd3, "mid_rst_r3", 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      cyc();
      chk("mid_post_retired", retired, 16'd0);
      read_reg(3'd1, "mid_post_r1", 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
